// File: rtl/mem_dma.sv
// ---------------------------------------------------------------------------
// mem_dma
//
// Purpose:
//   Small bus-initiator DMA engine for a local single-port RAM. It can either
//   copy a block of words from a source range to a destination range (one read
//   and one write per word) or fill a destination range with a constant
//   pattern (one write per word). Addresses wrap modulo 2^ADDR_W. The RAM never
//   stalls, and read data arrives exactly one cycle after a read request.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset_n    : synchronous active-low reset
//   start      : single-cycle request, ignored while busy
//   mode       : 0 = copy src->dst, 1 = fill dst with fill_data
//   src_addr   : first source word address (copy only)
//   dst_addr   : first destination word address
//   len        : number of words to transfer (0 completes immediately)
//   fill_data  : fill pattern (fill only)
//   abort      : stop an active transfer after the current bus access
//   busy       : high while reading or writing
//   done       : one-cycle completion pulse (not raised on abort)
//   mem_wr     : byte write enables to the RAM
//   mem_rd     : read request to the RAM
//   mem_addr   : word address to the RAM
//   mem_wdata  : write data to the RAM
//   mem_rdata  : RAM read data, valid the cycle after mem_rd
// ---------------------------------------------------------------------------
module mem_dma #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic [31:0]       fill_data,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [3:0]        mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic              mode_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] srcPtr_q;
   logic [ADDR_W-1:0] dstPtr_q;
   logic [31:0]       fill_q;

   logic              busy_q;
   logic              done_q;
   logic [3:0]        memWr_q;
   logic              memRd_q;
   logic [ADDR_W-1:0] memAddr_q;

   logic [ADDR_W-1:0] cntInc_d;
   logic [ADDR_W-1:0] srcInc_d;
   logic [ADDR_W-1:0] dstInc_d;
   logic              lastWord_d;

   // Incremented word counter and pointers for the word after the current
   // one. The pointers wrap naturally at the top of the address space.
   always_comb begin
      cntInc_d   = cnt_q + ADDR_W'(1);
      srcInc_d   = srcPtr_q + ADDR_W'(1);
      dstInc_d   = dstPtr_q + ADDR_W'(1);
      lastWord_d = (cntInc_d == len_q);
   end

   // Transfer FSM. Bus outputs are registered: every transition into READ or
   // WRITE loads the strobes and address that belong to the state being
   // entered, and they default back to idle values otherwise. abort is only
   // looked at in READ/WRITE, so the access already on the bus in that cycle
   // still completes. abort also takes priority over reaching the last word.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         srcPtr_q  <= '0;
         dstPtr_q  <= '0;
         fill_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         memWr_q   <= 4'h0;
         memRd_q   <= 1'b0;
         memAddr_q <= '0;
      end else begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         memWr_q <= 4'h0;
         memRd_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  mode_q   <= mode;
                  len_q    <= len;
                  fill_q   <= fill_data;
                  cnt_q    <= '0;
                  srcPtr_q <= src_addr;
                  dstPtr_q <= dst_addr;
                  if (len == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (!mode) begin
                     state_q   <= READ;
                     busy_q    <= 1'b1;
                     memRd_q   <= 1'b1;
                     memAddr_q <= src_addr;
                  end else begin
                     state_q   <= WRITE;
                     busy_q    <= 1'b1;
                     memWr_q   <= 4'hF;
                     memAddr_q <= dst_addr;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            READ: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  state_q   <= WRITE;
                  busy_q    <= 1'b1;
                  memWr_q   <= 4'hF;
                  memAddr_q <= dstPtr_q;
               end
            end
            WRITE: begin
               cnt_q    <= cntInc_d;
               srcPtr_q <= srcInc_d;
               dstPtr_q <= dstInc_d;
               if (abort) begin
                  state_q <= IDLE;
               end else if (lastWord_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else if (!mode_q) begin
                  state_q   <= READ;
                  busy_q    <= 1'b1;
                  memRd_q   <= 1'b1;
                  memAddr_q <= srcInc_d;
               end else begin
                  state_q   <= WRITE;
                  busy_q    <= 1'b1;
                  memWr_q   <= 4'hF;
                  memAddr_q <= dstInc_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Write data cannot be registered in copy mode: the word read in READ only
   // shows up on mem_rdata during the following WRITE cycle, so it is passed
   // straight through. Outside WRITE the data bus is held at zero.
   always_comb begin
      mem_wdata = '0;
      if (state_q == WRITE) begin
         mem_wdata = mode_q ? fill_q : mem_rdata;
      end
   end

   // Registered status and bus strobes straight to the ports.
   always_comb begin
      busy     = busy_q;
      done     = done_q;
      mem_wr   = memWr_q;
      mem_rd   = memRd_q;
      mem_addr = memAddr_q;
   end

endmodule
